bus_ctrl: RTL and testbench

Bus-side sequencer for the structural CPU datapath. It accepts a 9-bit instruction and drives `buswires`. It also pulses the one-hot `rin` load enables of eight `reg16` registers (R0–R7), so each register captures the bus on the matching clock edge. It owns the instruction register, the A operand register and the G result register, and performs 16-bit add/sub for two-operand instructions.

---
 rtl/bus_ctrl_if.sv | 28 ++
 rtl/bus_ctrl.sv | 116 +++++++++++
 tb/tb_bus_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_ctrl_if.sv
// bus_ctrl_if: groups the sequencer's handshake and bus signals.
//   run      start request (sampled only when idle)
//   din      instruction word in idle, immediate data during mvi T1
//   rdata    packed outputs of R0..R7, R_i = rdata[16i+15:16i]
//   buswires shared 16-bit data bus into all registers
//   rin      one-hot register load enables
//   busy     high whenever the sequencer is not idle
//   done     one-cycle pulse in the final cycle of an instruction
// master: the sequencer side; slave: the register file / environment side.
interface bus_ctrl_if;
  logic         run;
  logic [15:0]  din;
  logic [127:0] rdata;
  logic [15:0]  buswires;
  logic [7:0]   rin;
  logic         busy;
  logic         done;

  modport master (
    input  run, din, rdata,
    output buswires, rin, busy, done
  );

  modport slave (
    output run, din, rdata,
    input  buswires, rin, busy, done
  );
endinterface

// File: rtl/bus_ctrl.sv
// bus_ctrl: bus-side sequencer for the structural CPU datapath.
// Decodes a 9-bit instruction {op, x, y}, drives the shared bus from a combinational
// source mux and pulses one-hot register load enables. Owns IR, the A operand register
// and the G result register, and performs 16-bit modulo add/sub.
// Ports:
//   clock   rising-edge clock shared with the register file
//   resetn  synchronous active-low reset
//   bif     bus_ctrl_if master modport (run, din, rdata in; buswires, rin, busy, done out)
module bus_ctrl (
  input logic       clock,
  input logic       resetn,
  bus_ctrl_if.master bif
);

  typedef enum logic [1:0] {StIdle, StT1, StT2, StT3} state_e;

  localparam logic [2:0] OpMv  = 3'b000;
  localparam logic [2:0] OpMvi = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;

  state_e      state_q, state_d;
  logic [8:0]  ir_q, ir_d;
  logic [15:0] a_q, a_d;
  logic [15:0] g_q, g_d;

  logic [2:0]  op, x, y;
  logic [15:0] rx, ry;
  logic [15:0] bus_val;
  logic [7:0]  rin_raw;
  logic        done_int;

  assign op = ir_q[8:6];
  assign x  = ir_q[5:3];
  assign y  = ir_q[2:0];
  assign rx = bif.rdata[{x, 4'h0} +: 16];
  assign ry = bif.rdata[{y, 4'h0} +: 16];

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    a_d      = a_q;
    g_d      = g_q;
    bus_val  = 16'h0000;
    rin_raw  = 8'h00;
    done_int = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bif.run) begin
          ir_d    = bif.din[8:0];
          state_d = StT1;
        end
      end
      StT1: begin
        unique case (op)
          OpMv: begin
            bus_val    = ry;
            rin_raw[x] = 1'b1;
            done_int   = 1'b1;
            state_d    = StIdle;
          end
          OpMvi: begin
            bus_val    = bif.din;
            rin_raw[x] = 1'b1;
            done_int   = 1'b1;
            state_d    = StIdle;
          end
          OpAdd, OpSub: begin
            bus_val = rx;
            a_d     = rx;
            state_d = StT2;
          end
          default: begin
            // Opcodes 100-111 retire as no-ops with an empty bus.
            done_int = 1'b1;
            state_d  = StIdle;
          end
        endcase
      end
      StT2: begin
        bus_val = ry;
        // op[0] distinguishes sub (011) from add (010); carry/borrow dropped.
        g_d     = op[0] ? (a_q - ry) : (a_q + ry);
        state_d = StT3;
      end
      StT3: begin
        bus_val    = g_q;
        rin_raw[x] = 1'b1;
        done_int   = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= StIdle;
      ir_q    <= 9'h000;
      a_q     <= 16'h0000;
      g_q     <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
    end
  end

  // Load enables are gated by reset so an abort in T1/T3 never writes a register.
  assign bif.rin      = resetn ? rin_raw : 8'h00;
  assign bif.buswires = bus_val;
  assign bif.busy     = (state_q != StIdle);
  assign bif.done     = done_int;

endmodule

// File: tb/tb_bus_ctrl.sv
// tb_bus_ctrl: scoreboard bench for bus_ctrl with a behavioural R0..R7 register file.
module tb_bus_ctrl;

  logic clock = 1'b0;
  logic resetn;

  bus_ctrl_if bif ();

  bus_ctrl dut (
    .clock  (clock),
    .resetn (resetn),
    .bif    (bif)
  );

  always #5 clock = ~clock;

  // Register file: each reg16 captures the bus when its load enable is high.
  logic [15:0] regs [8];
  always_ff @(posedge clock) begin
    for (int i = 0; i < 8; i++) begin
      if (bif.rin[i]) regs[i] <= bif.buswires;
    end
  end

  always_comb begin
    bif.rdata = '0;
    for (int i = 0; i < 8; i++) bif.rdata[16*i +: 16] = regs[i];
  end

  typedef struct packed {
    logic        wr;
    logic [2:0]  dst;
    logic [15:0] val;
  } exp_t;

  exp_t        sbq [$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_regs [8];
  logic [15:0] init_vals [8] = '{16'h0123, 16'h4567, 16'h89ab, 16'hcdef,
                                 16'h1357, 16'h2468, 16'h9bdf, 16'h7001};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < 8; i++) check($sformatf("%s_r%0d", name, i), 32'(regs[i]), 32'(exp_regs[i]));
  endtask

  // Monitor: pops one expectation per done pulse; rin must be quiet otherwise.
  always @(negedge clock) begin
    if (!resetn) begin
      check("rin_in_reset", 32'(bif.rin), 32'h0);
    end else if (bif.done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done required=no_done");
      end else begin
        mon_e = sbq.pop_front();
        check("done_rin", 32'(bif.rin), mon_e.wr ? 32'(8'h01 << mon_e.dst) : 32'h0);
        if (mon_e.wr) check("done_bus", 32'(bif.buswires), 32'(mon_e.val));
      end
    end else begin
      check("rin_quiet", 32'(bif.rin), 32'h0);
    end
  end

  function automatic logic [15:0] instr(input logic [2:0] op, x, y);
    return {7'h5a, op, x, y};  // upper bits are junk the DUT must ignore
  endfunction

  task automatic push_exp(input bit wr, input logic [2:0] x, input logic [15:0] val);
    if (wr) begin
      sbq.push_back({1'b1, x, val});
      exp_regs[x] = val;
    end else begin
      sbq.push_back({1'b0, 3'd0, 16'h0000});
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the first idle negedge after it.
  task automatic issue(input logic [2:0] op, x, y, input logic [15:0] imm, input bit wr,
                       input logic [15:0] val, input int lat, input bit pulse,
                       input string name);
    int n;
    push_exp(wr, x, val);
    bif.run = 1'b1;
    bif.din = instr(op, x, y);
    @(posedge clock);
    #1;
    bif.run = 1'b0;
    bif.din = imm;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (!bif.busy) begin
        bif.run = 1'b0;
        break;
      end
      n++;
      if (pulse) bif.run = 1'b1;
    end
    check({name, "_busy_cycles"}, 32'(n), 32'(lat));
  endtask

  logic [15:0] b2b_instr [3];
  logic [15:0] b2b_val [3];
  logic [2:0]  b2b_dst [3];
  int          b2b_lat [3];

  initial begin
    bif.run = 1'b0;
    bif.din = 16'h0000;
    resetn  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    check("idle_busy", 32'(bif.busy), 32'h0);
    check("idle_bus", 32'(bif.buswires), 32'h0);

    // Preload arbitrary values through mvi.
    for (int i = 0; i < 8; i++)
      issue(3'b001, 3'(i), 3'd0, init_vals[i], 1'b1, init_vals[i], 1, 1'b0, "preload");
    check_regs("preload");

    // Reset held for 10 cycles with run low.
    @(posedge clock);
    #1;
    resetn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("rst_bus", 32'(bif.buswires), 32'h0);
      check("rst_busy", 32'(bif.busy), 32'h0);
      check("rst_done", 32'(bif.done), 32'h0);
    end
    check_regs("after_reset");
    @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);

    // Directed instruction vectors.
    issue(3'b001, 3'd5, 3'd0, 16'hbeef, 1'b1, 16'hbeef, 1, 1'b0, "mvi_r5");
    issue(3'b000, 3'd1, 3'd5, 16'h0000, 1'b1, 16'hbeef, 1, 1'b0, "mv_r1_r5");
    issue(3'b001, 3'd2, 3'd0, 16'hffff, 1'b1, 16'hffff, 1, 1'b0, "mvi_r2");
    issue(3'b001, 3'd3, 3'd0, 16'h0002, 1'b1, 16'h0002, 1, 1'b0, "mvi_r3");
    issue(3'b010, 3'd2, 3'd3, 16'h0000, 1'b1, 16'h0001, 3, 1'b0, "add_r2_r3");
    issue(3'b011, 3'd3, 3'd2, 16'h0000, 1'b1, 16'h0001, 3, 1'b0, "sub_r3_r2");
    issue(3'b001, 3'd4, 3'd0, 16'h4000, 1'b1, 16'h4000, 1, 1'b0, "mvi_r4");
    issue(3'b010, 3'd4, 3'd4, 16'h0000, 1'b1, 16'h8000, 3, 1'b0, "add_r4_r4");
    issue(3'b000, 3'd2, 3'd2, 16'h0000, 1'b1, 16'h0001, 1, 1'b0, "mv_r2_r2");
    issue(3'b101, 3'd2, 3'd3, 16'hffff, 1'b0, 16'h0000, 1, 1'b0, "noop_101");
    issue(3'b011, 3'd6, 3'd6, 16'h0000, 1'b1, 16'h0000, 3, 1'b0, "sub_r6_r6");
    check_regs("directed");

    // run pulsed during T1-T3 with a junk mvi on din: must not restart.
    issue(3'b010, 3'd7, 3'd5, 16'h0047, 1'b1, 16'h2ef0, 3, 1'b1, "add_r7_r5_pulse");
    check("pulse_idle_stays", 32'(bif.busy), 32'h0);

    // run held high across three instructions: exactly one idle cycle between them.
    b2b_instr = '{instr(3'b000, 3'd0, 3'd5), instr(3'b010, 3'd0, 3'd1), instr(3'b000, 3'd6, 3'd0)};
    b2b_dst   = '{3'd0, 3'd0, 3'd6};
    b2b_val   = '{16'hbeef, 16'h7dde, 16'h7dde};
    b2b_lat   = '{1, 3, 1};
    for (int k = 0; k < 3; k++) begin
      int n;
      push_exp(1'b1, b2b_dst[k], b2b_val[k]);
      bif.run = 1'b1;
      bif.din = b2b_instr[k];
      @(posedge clock);
      #1;
      bif.din = instr(3'b001, 3'd7, 3'd7);
      n = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clock);
        if (!bif.busy) break;
        n++;
      end
      check($sformatf("b2b%0d_busy_cycles", k), 32'(n), 32'(b2b_lat[k]));
    end
    bif.run = 1'b0;
    @(negedge clock);
    check("b2b_stop", 32'(bif.busy), 32'h0);
    check_regs("b2b");

    // Reset during T3 of add R2,R3 aborts without writing R2.
    bif.run = 1'b1;
    bif.din = instr(3'b010, 3'd2, 3'd3);
    @(posedge clock);
    #1;
    bif.run = 1'b0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    resetn = 1'b0;
    @(negedge clock);
    check("abort_t3_rin", 32'(bif.rin), 32'h0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("abort_bus", 32'(bif.buswires), 32'h0);
    check("abort_busy", 32'(bif.busy), 32'h0);
    check("abort_done", 32'(bif.done), 32'h0);
    check_regs("abort");
    @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    issue(3'b000, 3'd2, 3'd7, 16'h0000, 1'b1, 16'h2ef0, 1, 1'b0, "post_abort_mv");
    issue(3'b010, 3'd3, 3'd3, 16'h0000, 1'b1, 16'h0002, 3, 1'b0, "post_abort_add");
    check_regs("final");
    check("queue_drained", 32'(sbq.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
